// File: rtl/input_buffer_pkg.sv
// Shared constants and lane type for the four-lane NPU input staging register.
package input_buffer_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_LANES = 4;

    typedef logic [DATA_W-1:0] lane_t;

endpackage : input_buffer_pkg

// File: rtl/buf_lane_reg.sv
// One lane of the input buffer: a DATA_W register with synchronous clear, load enable and hold.
module buf_lane_reg
    import input_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = input_buffer_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear wins over load; otherwise the lane holds.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : buf_lane_reg

// File: rtl/input_buffer.sv
// Four-lane input staging register; all lanes share clock, clear and enable.
// Defining INPUT_BUFFER_VALID_EN adds VALID_BUF_IN, set by a load and cleared by CLR_BUF_IN.
module input_buffer
    import input_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = input_buffer_pkg::DATA_W
) (
    input  logic              CLKEXT,
    input  logic              CLR_BUF_IN,
    input  logic              EN_BUF_IN,
    input  logic [DATA_W-1:0] DA,
    input  logic [DATA_W-1:0] DB,
    input  logic [DATA_W-1:0] DC,
    input  logic [DATA_W-1:0] DD,
    output logic [DATA_W-1:0] QA,
    output logic [DATA_W-1:0] QB,
    output logic [DATA_W-1:0] QC,
    output logic [DATA_W-1:0] QD
`ifdef INPUT_BUFFER_VALID_EN
    ,
    output logic              VALID_BUF_IN
`endif
);

    buf_lane_reg #(.DATA_W(DATA_W)) u_lane_a (
        .clk (CLKEXT),
        .clr (CLR_BUF_IN),
        .en  (EN_BUF_IN),
        .d   (DA),
        .q   (QA)
    );

    buf_lane_reg #(.DATA_W(DATA_W)) u_lane_b (
        .clk (CLKEXT),
        .clr (CLR_BUF_IN),
        .en  (EN_BUF_IN),
        .d   (DB),
        .q   (QB)
    );

    buf_lane_reg #(.DATA_W(DATA_W)) u_lane_c (
        .clk (CLKEXT),
        .clr (CLR_BUF_IN),
        .en  (EN_BUF_IN),
        .d   (DC),
        .q   (QC)
    );

    buf_lane_reg #(.DATA_W(DATA_W)) u_lane_d (
        .clk (CLKEXT),
        .clr (CLR_BUF_IN),
        .en  (EN_BUF_IN),
        .d   (DD),
        .q   (QD)
    );

`ifdef INPUT_BUFFER_VALID_EN
    // Marks that the lanes hold data loaded since the last clear.
    always_ff @(posedge CLKEXT) begin
        if (CLR_BUF_IN) begin
            VALID_BUF_IN <= 1'b0;
        end else if (EN_BUF_IN) begin
            VALID_BUF_IN <= 1'b1;
        end
    end
`endif

endmodule : input_buffer

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: directed test-plan sequences plus randomized traffic vs. a lane model.
module tb_input_buffer;
    import input_buffer_pkg::*;

    logic  clk;
    logic  clr;
    logic  en;
    lane_t da, db, dc, dd;
    lane_t qa, qb, qc, qd;
`ifdef INPUT_BUFFER_VALID_EN
    logic  valid;
`endif

    int    vectors   = 0;
    int    miscompares = 0;

    // Reference state: expected content of each lane and the loaded-since-clear flag.
    lane_t exp_q [4];
    logic  exp_valid;

    input_buffer dut (
        .CLKEXT     (clk),
        .CLR_BUF_IN (clr),
        .EN_BUF_IN  (en),
        .DA         (da),
        .DB         (db),
        .DC         (dc),
        .DD         (dd),
        .QA         (qa),
        .QB         (qb),
        .QC         (qc),
        .QD         (qd)
`ifdef INPUT_BUFFER_VALID_EN
        ,
        .VALID_BUF_IN (valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Apply one edge worth of inputs, advance the model, then compare all lanes after the edge.
    task automatic step(input logic c, input logic e,
                        input lane_t a, input lane_t b, input lane_t cc, input lane_t d);
        @(negedge clk);
        clr = c; en = e; da = a; db = b; dc = cc; dd = d;
        @(posedge clk);
        if (c) begin
            foreach (exp_q[i]) exp_q[i] = '0;
            exp_valid = 1'b0;
        end else if (e) begin
            exp_q[0] = a; exp_q[1] = b; exp_q[2] = cc; exp_q[3] = d;
            exp_valid = 1'b1;
        end
        #1;
        check("qa", 32'(qa), 32'(exp_q[0]));
        check("qb", 32'(qb), 32'(exp_q[1]));
        check("qc", 32'(qc), 32'(exp_q[2]));
        check("qd", 32'(qd), 32'(exp_q[3]));
`ifdef INPUT_BUFFER_VALID_EN
        check("valid", 32'(valid), 32'(exp_valid));
`endif
    endtask

    task automatic expect_all(input string tag, input lane_t a, input lane_t b, input lane_t c, input lane_t d);
        check({tag, "_qa"}, 32'(qa), 32'(a));
        check({tag, "_qb"}, 32'(qb), 32'(b));
        check({tag, "_qc"}, 32'(qc), 32'(c));
        check({tag, "_qd"}, 32'(qd), 32'(d));
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; da = '0; db = '0; dc = '0; dd = '0;
        foreach (exp_q[i]) exp_q[i] = '0;
        exp_valid = 1'b0;

        // Clear for two edges.
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        expect_all("clear", 8'h00, 8'h00, 8'h00, 8'h00);

        // Single load.
        step(1'b0, 1'b1, 8'h01, 8'h05, 8'hFF, 8'h1D);
        expect_all("load", 8'h01, 8'h05, 8'hFF, 8'h1D);

        // Hold while D toggles.
        step(1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        step(1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        expect_all("hold", 8'h01, 8'h05, 8'hFF, 8'h1D);

        // Clear beats enable.
        step(1'b0, 1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        expect_all("preload", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        step(1'b1, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78);
        expect_all("prio", 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef INPUT_BUFFER_VALID_EN
        check("prio_valid", 32'(valid), 32'd0);
`endif

        // Back-to-back streaming.
        step(1'b0, 1'b1, 8'h10, 8'h10, 8'h10, 8'h10);
        expect_all("stream0", 8'h10, 8'h10, 8'h10, 8'h10);
`ifdef INPUT_BUFFER_VALID_EN
        check("stream_valid", 32'(valid), 32'd1);
`endif
        step(1'b0, 1'b1, 8'h20, 8'h20, 8'h20, 8'h20);
        expect_all("stream1", 8'h20, 8'h20, 8'h20, 8'h20);
        step(1'b0, 1'b1, 8'h30, 8'h30, 8'h30, 8'h30);
        expect_all("stream2", 8'h30, 8'h30, 8'h30, 8'h30);

        // Clear in the middle of a stream.
        step(1'b0, 1'b1, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
        expect_all("mid0", 8'h5A, 8'h5A, 8'h5A, 8'h5A);
        step(1'b1, 1'b0, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
        expect_all("mid1", 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        expect_all("mid2", 8'hA5, 8'hA5, 8'hA5, 8'hA5);

        // Randomized traffic: sparse clears, roughly half the edges load.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_input_buffer

// File: doc/input_buffer.md
Name: input_buffer

Overview:
- Four-lane input staging register at the NPU data entry point.
- Captures four 8-bit operands (DA..DD) on an enable strobe and holds them stable for downstream compute logic until the next load or clear.
- Purely clocked storage: no combinational path from D inputs to Q outputs.

Parameters:
- DATA_W, 8, width in bits of each lane (DA..DD, QA..QD).

Ports:
- CLKEXT  input  1  system clock; all state updates on rising edge.
- CLR_BUF_IN  input  1  reset/clear; synchronous, active-high.
- EN_BUF_IN  input  1  load enable; active-high, sampled on rising CLKEXT.
- DA  input  DATA_W  lane A data in.
- DB  input  DATA_W  lane B data in.
- DC  input  DATA_W  lane C data in.
- DD  input  DATA_W  lane D data in.
- QA  output  DATA_W  lane A registered data out.
- QB  output  DATA_W  lane B registered data out.
- QC  output  DATA_W  lane C registered data out.
- QD  output  DATA_W  lane D registered data out.
- Interface decision: one clock (CLKEXT); reset CLR_BUF_IN is synchronous and active-high.

Behaviour:
- Reset: on a rising CLKEXT with CLR_BUF_IN=1, QA=QB=QC=QD=0. No asynchronous effect.
- Load: on a rising CLKEXT with CLR_BUF_IN=0 and EN_BUF_IN=1, each Qx takes the Dx value sampled at that edge. Latency is 1 edge; the new value is visible after that edge.
- Hold: with CLR_BUF_IN=0 and EN_BUF_IN=0, all Qx keep their value indefinitely, regardless of D activity.
- Priority: CLR_BUF_IN over EN_BUF_IN. Both high gives all Q=0.
- All four lanes share one enable; partial-lane load is not possible.
- Data passes through unmodified: no arithmetic, no sign or width conversion.
- Clear mid-operation: an asserted CLR on any edge zeroes all lanes on that edge, discarding held data. Loading resumes on the first edge with CLR=0 and EN=1.
- Back-to-back loads: EN held high captures new D every cycle.
- Before the first clear, Q is undefined (X in simulation). Benches must clear first.
- No handshake or back-pressure. The upstream source must hold D stable around the capture edge.

Optional Feature:
- Macro INPUT_BUFFER_VALID_EN.
- Defined: adds output VALID_BUF_IN (1 bit).
  - Cleared to 0 by CLR_BUF_IN.
  - Set to 1 on any load edge (CLR=0, EN=1).
  - Holds otherwise. It indicates that Q holds data loaded since the last clear.
- Not defined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package input_buffer_pkg:
  - DATA_W default constant (8).
  - NUM_LANES constant (4).
  - typedef lane_t as a DATA_W-bit vector.
- Sub-module buf_lane_reg: one DATA_W register with synchronous active-high clear, enable, and hold. It is instantiated four times (A..D) sharing CLKEXT, CLR_BUF_IN and EN_BUF_IN.
- The top level contains only instantiation, plus the optional valid flag.

Test Plan:
- Clear: CLR_BUF_IN=1, EN_BUF_IN=0, D=00 for 2 edges -> QA..QD=00.
- Load: CLR=0, EN=1, DA=01 DB=05 DC=FF DD=1D, one edge -> QA=01 QB=05 QC=FF QD=1D on that edge.
- Hold: EN=0, DA=11 DB=22 DC=33 DD=44 for 2 edges -> Q remains 01/05/FF/1D.
- Priority: load AA/BB/CC/DD, then CLR=1 and EN=1 with D=12/34/56/78 -> all Q=00. With macro, VALID_BUF_IN=0.
- Streaming: EN=1 for 3 consecutive edges with D=10,20,30 on all lanes -> Q follows one edge later: 10, 20, 30. With macro, VALID_BUF_IN=1 after the first edge.
- Mid-stream clear: load 5A on all lanes, assert CLR for one edge, then EN=1 with D=A5 -> Q goes 5A, 00, A5 on successive edges.
